// File: rtl/decodificador_velocidad.sv
// Decodificador de velocidad: recovers a 3-bit speed pattern sent serially,
// one bit per window of a frame, where windows are defined by ranges of the
// frame position counter. Each frame is majority-decoded per window, and
// the block reports a frame as suspect when a window is empty or mixed.
//
// Handshake: valid is a one-clk strobe with no ready; v_dec and err change
// only on that strobe (or, for err, on a timeout) and hold otherwise.
module decodificador_velocidad #(
  parameter int UMBRAL_MEDIO = 250,
  parameter int UMBRAL_ALTO  = 350,
  parameter int CW           = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [8:0] contador,
  input  logic       in,
  output logic [2:0] v_dec,
  output logic       valid,
  output logic       err,
  output logic       sync
);

  typedef enum logic {
    S_SYNC = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  localparam logic [8:0] U_MED  = 9'(UMBRAL_MEDIO);
  localparam logic [8:0] U_ALTO = 9'(UMBRAL_ALTO);
  localparam logic [9:0] T_LAST = 10'd1023;

  state_t        state, state_nx;
  logic [8:0]    c_s, c_prev;
  logic [1:0]    win;
  logic          wrap;
  logic          timeout;
  logic [9:0]    tcnt;
  logic [CW-1:0] ones  [3];
  logic [CW-1:0] total [3];
  logic [2:0]    dec;
  logic [2:0]    bad;

  // Delay contador by one clk so it lines up with the serial bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      c_s    <= '0;
      c_prev <= '0;
    end else begin
      c_s    <= contador;
      c_prev <= c_s;
    end
  end

  // Window of the current sample, frame-start detection and timeout condition.
  always_comb begin
    win = 2'd0;
    if (c_s >= U_ALTO)      win = 2'd2;
    else if (c_s >= U_MED)  win = 2'd1;
    wrap    = (c_s < c_prev);
    timeout = (state == S_RUN) && !wrap && (tcnt == T_LAST);
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_SYNC;
    else        state <= state_nx;
  end

  // Next state: first wrap locks on, a long gap without wraps drops lock.
  always_comb begin
    state_nx = state;
    case (state)
      S_SYNC:  if (wrap) state_nx = S_RUN;
      S_RUN:   if (timeout) state_nx = S_SYNC;
      default: state_nx = S_SYNC;
    endcase
  end

  assign sync = (state == S_RUN);

  // Count consecutive wrap-free clks while locked.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                           tcnt <= '0;
    else if ((state == S_RUN) && !wrap)   tcnt <= tcnt + 10'd1;
    else                                  tcnt <= '0;
  end

  // Per-window sample counters; a wrap starts a new frame with its own sample.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int w = 0; w < 3; w++) begin
        ones[w]  <= '0;
        total[w] <= '0;
      end
    end else begin
      for (int w = 0; w < 3; w++) begin
        if (wrap) begin
          total[w] <= (win == 2'(w)) ? CW'(1) : '0;
          ones[w]  <= ((win == 2'(w)) && in) ? CW'(1) : '0;
        end else if (timeout) begin
          total[w] <= '0;
          ones[w]  <= '0;
        end else if ((state == S_RUN) && (win == 2'(w))) begin
          if (total[w] != '1)          total[w] <= total[w] + CW'(1);
          if (in && (ones[w] != '1))   ones[w]  <= ones[w] + CW'(1);
        end
      end
    end
  end

  // Strict-majority decode and per-window sanity of the frame being closed.
  always_comb begin
    dec = '0;
    bad = '0;
    for (int w = 0; w < 3; w++) begin
      dec[w] = ({ones[w], 1'b0} > {1'b0, total[w]});
      bad[w] = (total[w] == '0) || ((ones[w] != '0) && (ones[w] != total[w]));
    end
  end

  // Publish the decoded frame on a wrap while locked; flag lost lock on timeout.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_dec <= '0;
      err   <= 1'b0;
      valid <= 1'b0;
    end else begin
      valid <= 1'b0;
      if ((state == S_RUN) && wrap) begin
        v_dec <= dec;
        err   <= |bad;
        valid <= 1'b1;
      end else if (timeout) begin
        err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_decodificador_velocidad.sv
// Bench for decodificador_velocidad: drives frames of contador sweeps with a
// serial bit lagging by one clk, and predicts each decoded frame from the
// list of samples it contained.
module tb_decodificador_velocidad;

  localparam int W = 36;  // {valid cycle[31:0], v_dec[2:0], err}

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [8:0] contador = '0;
  logic       in = 1'b0;
  logic [2:0] v_dec;
  logic       valid;
  logic       err;
  logic       sync;

  decodificador_velocidad dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .contador (contador),
    .in       (in),
    .v_dec    (v_dec),
    .valid    (valid),
    .err      (err),
    .sync     (sync)
  );

  // Clock.
  always #5 clk = ~clk;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   rst_hold = 0;
  bit   pend_b = 1'b0;

  logic [W-1:0] exp_q[$];

  // Reference model state: samples of the open frame and lock status.
  int       fr_c[$];
  bit       fr_b[$];
  int       m_prev = 0;
  bit       m_run = 1'b0;
  int       m_idle = 0;
  logic [2:0] m_last_v = '0;
  bit       m_last_err = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    if (obs !== expv) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, expv, cyc);
    end
  endtask

  function automatic int win_of(input int c);
    if (c >= 350) return 2;
    if (c >= 250) return 1;
    return 0;
  endfunction

  // Frame-level reference: a drop in contador closes the frame; decode it by
  // counting the recorded samples of each window.
  task automatic model_sample(input int c, input bit b);
    int         on[3];
    int         tot[3];
    logic [2:0] v;
    bit         e;
    if (c < m_prev) begin
      if (m_run) begin
        for (int w = 0; w < 3; w++) begin
          on[w] = 0;
          tot[w] = 0;
        end
        for (int i = 0; i < fr_c.size(); i++) begin
          tot[win_of(fr_c[i])]++;
          if (fr_b[i]) on[win_of(fr_c[i])]++;
        end
        e = 1'b0;
        for (int w = 0; w < 3; w++) begin
          v[w] = (2 * on[w] > tot[w]);
          if (tot[w] == 0 || (on[w] > 0 && on[w] < tot[w])) e = 1'b1;
        end
        exp_q.push_back({32'(cyc + 2), v, e});
        m_last_v = v;
        m_last_err = e;
      end
      m_run = 1'b1;
      m_idle = 0;
      fr_c.delete();
      fr_b.delete();
    end else if (m_run) begin
      m_idle++;
      if (m_idle == 1024) begin
        m_run = 1'b0;
        m_last_err = 1'b1;
      end
    end
    if (m_run) begin
      fr_c.push_back(c);
      fr_b.push_back(b);
    end
    m_prev = c;
  endtask

  // Scoreboard: every valid must match the oldest prediction at its cycle.
  task automatic monitor();
    logic [W-1:0] e;
    logic [31:0]  ecyc;
    if (valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("valid_spurious", 32'(valid), 32'd0);
      end else begin
        e = exp_q[0];
        ecyc = e[35:4];
        if (ecyc != 32'(cyc)) begin
          check("valid_spurious", 32'(valid), 32'd0);
        end else begin
          void'(exp_q.pop_front());
          check("valid_vdec", 32'(v_dec), 32'(e[3:1]));
          check("valid_err", 32'(err), 32'(e[0]));
          check("sync_at_valid", 32'(sync), 32'd1);
        end
      end
    end else if (exp_q.size() > 0) begin
      e = exp_q[0];
      ecyc = e[35:4];
      if (ecyc <= 32'(cyc)) begin
        check("valid_missing", 32'(valid), 32'd1);
        void'(exp_q.pop_front());
      end
    end
  endtask

  // Driver: one clk per sample; in carries the bit of the previous contador.
  task automatic step(input int c, input bit b);
    @(negedge clk);
    cyc++;
    monitor();
    if (rst_hold > 0) begin
      rst_hold--;
      if (rst_hold == 0) rst_n = 1'b1;
    end
    contador = 9'(c);
    in = pend_b;
    pend_b = b;
    if (rst_n) begin
      model_sample(c, b);
    end else begin
      m_run = 1'b0;
      m_prev = 0;
      m_idle = 0;
    end
  endtask

  // Sweep contador first..last with exactly k[w] ones scattered randomly in
  // window w (negative or oversized k means every sample of that window is 1).
  task automatic drive_frame(input int first, input int last, input int k0, input int k1, input int k2);
    int n[3];
    int k[3];
    int w;
    bit b;
    for (int i = 0; i < 3; i++) n[i] = 0;
    for (int c = first; c <= last; c++) n[win_of(c)]++;
    k[0] = k0;
    k[1] = k1;
    k[2] = k2;
    for (int i = 0; i < 3; i++) if (k[i] < 0 || k[i] > n[i]) k[i] = n[i];
    for (int c = first; c <= last; c++) begin
      w = win_of(c);
      b = (int'($urandom_range(n[w] - 1, 0)) < k[w]);
      n[w]--;
      if (b) k[w]--;
      step(c, b);
    end
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_vdec"}, 32'(v_dec), 32'd0);
    check({tag, "_valid"}, 32'(valid), 32'd0);
    check({tag, "_err"}, 32'(err), 32'd0);
    check({tag, "_sync"}, 32'(sync), 32'd0);
  endtask

  initial begin
    // Power-on reset, released part way through an initial partial sweep.
    #1 rst_n = 1'b0;
    #1 check_reset_values("rst");
    rst_hold = 3;
    drive_frame(200, 399, -1, 0, -1);

    // Pattern 101: first wrap only locks, later wraps decode.
    drive_frame(0, 399, -1, 0, -1);
    check("sync_after_lock", 32'(sync), 32'd1);
    drive_frame(0, 399, -1, 0, -1);
    drive_frame(0, 399, -1, 0, -1);

    // Mixed window 0 (100 of 250), window 1 all ones, window 2 all zeros.
    drive_frame(0, 399, 100, -1, 0);
    // Exact tie in window 1.
    drive_frame(0, 399, int'($urandom_range(250, 0)), 50, int'($urandom_range(50, 0)));
    // Short frame: window 2 never visited.
    drive_frame(0, 299, -1, -1, 0);

    // Random frame lengths and densities.
    repeat (6) begin
      drive_frame(0, int'($urandom_range(511, 100)),
                  int'($urandom_range(260, 0)), int'($urandom_range(110, 0)),
                  int'($urandom_range(170, 0)));
    end

    // Frozen contador: lock is lost, v_dec holds, err rises, no valid.
    drive_frame(0, 399, -1, 0, -1);
    repeat (1100) step(120, 1'($urandom_range(1, 0)));
    check("timeout_sync", 32'(sync), 32'(m_run));
    check("timeout_err", 32'(err), 32'(m_last_err));
    check("timeout_vdec", 32'(v_dec), 32'(m_last_v));
    drive_frame(0, 399, 0, -1, -1);
    check("relock_sync", 32'(sync), 32'd1);
    drive_frame(0, 399, -1, -1, 0);

    // Reset mid-frame at contador=300 of a 111 frame.
    drive_frame(0, 399, -1, -1, -1);
    drive_frame(0, 300, -1, -1, -1);
    rst_n = 1'b0;
    #1 check_reset_values("midrst");
    rst_hold = 3;
    drive_frame(301, 399, -1, -1, -1);
    drive_frame(0, 399, -1, -1, -1);
    drive_frame(0, 20, -1, -1, -1);
    repeat (4) step(20, 1'b0);

    check("exp_q_drained", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
